// File: rtl/health_manager_pkg.sv
// rtl/health_manager_pkg.sv - shared game types, HP width and saturating HP helpers
// Contents:
//   HP_W           : HP register width, shared with the HUD bar block
//   game_state_t   : PLAY / WIN / LOSE
//   player_state_t : ALIVE / INVULN
//   hp_dec, hp_inc : saturating HP arithmetic (no wrap-around)
package health_manager_pkg;

  localparam int HP_W = 4;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WIN  = 2'd1,
    LOSE = 2'd2
  } game_state_t;

  typedef enum logic {
    ALIVE  = 1'b0,
    INVULN = 1'b1
  } player_state_t;

  function automatic logic [HP_W-1:0] hp_dec(input logic [HP_W-1:0] hp);
    return (hp == '0) ? hp : hp - HP_W'(1);
  endfunction

  function automatic logic [HP_W-1:0] hp_inc(input logic [HP_W-1:0] hp,
                                             input logic [HP_W-1:0] max_hp);
    return (hp >= max_hp) ? max_hp : hp + HP_W'(1);
  endfunction

endpackage

// File: rtl/frame_countdown.sv
// rtl/frame_countdown.sv - loadable down-counter stepped by frame ticks
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : force count to 0 (highest priority)
//   load     : load LOAD_VAL (beats a coincident tick)
//   tick     : decrement a nonzero count
//   busy     : count != 0
//   last     : count == 1 (the next tick empties the counter)
module frame_countdown #(
  parameter int LOAD_VAL = 1,
  localparam int W = $clog2(LOAD_VAL + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic load,
  input  logic tick,
  output logic busy,
  output logic last
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= W'(LOAD_VAL);
    end else if (tick && busy) begin
      count <= count - W'(1);
    end
  end

  assign busy = (count != '0);
  assign last = (count == W'(1));

endmodule

// File: rtl/health_manager.sv
// rtl/health_manager.sv - player/boss hit points, i-frames, boss cooldown, win/lose
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   frame_tick       : one pulse per video frame
//   player_hit       : player struck (pulse)
//   boss_hit         : boss struck (pulse)
//   heal             : player +1 HP (pulse)
//   restart          : reload game (pulse), beats every other event
//   present_health   : player HP
//   present_bhealth  : boss HP
//   player_invuln    : player invulnerability window active
//   boss_flash       : boss cooldown active
//   win, lose        : sticky outcome until restart
module health_manager
  import health_manager_pkg::*;
#(
  parameter int PLAYER_MAX     = 3,
  parameter int BOSS_MAX       = 8,
  parameter int INVULN_FRAMES  = 60,
  parameter int BOSS_CD_FRAMES = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_tick,
  input  logic            player_hit,
  input  logic            boss_hit,
  input  logic            heal,
  input  logic            restart,
  output logic [HP_W-1:0] present_health,
  output logic [HP_W-1:0] present_bhealth,
  output logic            player_invuln,
  output logic            boss_flash,
  output logic            win,
  output logic            lose
);

  localparam logic [HP_W-1:0] P_MAX = HP_W'(PLAYER_MAX);
  localparam logic [HP_W-1:0] B_MAX = HP_W'(BOSS_MAX);

  game_state_t     game_q, game_d;
  player_state_t   pl_q, pl_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic [HP_W-1:0] bhp_q, bhp_d;

  logic active;
  logic p_hit_acc;
  logic b_hit_acc;
  logic heal_acc;
  logic tick_en;
  logic inv_last;
  logic cd_busy;
  logic inv_busy_unused;
  logic cd_last_unused;

  // Everything except restart is frozen outside PLAY; restart masks all
  // other events in its cycle.
  assign active    = (game_q == PLAY) && !restart;
  assign p_hit_acc = active && player_hit && (pl_q == ALIVE);
  assign b_hit_acc = active && boss_hit && !cd_busy;
  assign heal_acc  = active && heal && !p_hit_acc;
  assign tick_en   = active && frame_tick;

  frame_countdown #(.LOAD_VAL(INVULN_FRAMES)) u_invuln_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (restart),
    .load  (p_hit_acc),
    .tick  (tick_en),
    .busy  (inv_busy_unused),
    .last  (inv_last)
  );

  frame_countdown #(.LOAD_VAL(BOSS_CD_FRAMES)) u_boss_cd_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (restart),
    .load  (b_hit_acc),
    .tick  (tick_en),
    .busy  (cd_busy),
    .last  (cd_last_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game_q <= PLAY;
      pl_q   <= ALIVE;
      hp_q   <= P_MAX;
      bhp_q  <= B_MAX;
    end else begin
      game_q <= game_d;
      pl_q   <= pl_d;
      hp_q   <= hp_d;
      bhp_q  <= bhp_d;
    end
  end

  always_comb begin
    game_d = game_q;
    pl_d   = pl_q;
    hp_d   = hp_q;
    bhp_d  = bhp_q;

    if (restart) begin
      game_d = PLAY;
      pl_d   = ALIVE;
      hp_d   = P_MAX;
      bhp_d  = B_MAX;
    end else begin
      if (p_hit_acc) begin
        hp_d = hp_dec(hp_q);
      end else if (heal_acc) begin
        hp_d = hp_inc(hp_q, P_MAX);
      end

      if (b_hit_acc) begin
        bhp_d = hp_dec(bhp_q);
      end

      case (pl_q)
        ALIVE:   if (p_hit_acc) pl_d = INVULN;
        INVULN:  if (tick_en && inv_last) pl_d = ALIVE;
        default: pl_d = ALIVE;
      endcase

      // Outcome is decided from the registered HP, so it lands one cycle
      // after the HP register reads 0; player death is checked first.
      if (game_q == PLAY) begin
        if (hp_q == '0) begin
          game_d = LOSE;
        end else if (bhp_q == '0) begin
          game_d = WIN;
        end
      end
    end
  end

  assign present_health  = hp_q;
  assign present_bhealth = bhp_q;
  assign player_invuln   = (pl_q == INVULN);
  assign boss_flash      = cd_busy;
  assign win             = (game_q == WIN);
  assign lose            = (game_q == LOSE);

endmodule

// File: tb/tb_health_manager.sv
// tb/tb_health_manager.sv - directed self-checking bench for health_manager
module tb_health_manager;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       player_hit = 1'b0;
  logic       boss_hit = 1'b0;
  logic       heal = 1'b0;
  logic       restart = 1'b0;
  logic [3:0] present_health;
  logic [3:0] present_bhealth;
  logic       player_invuln;
  logic       boss_flash;
  logic       win;
  logic       lose;

  int tests_run = 0;
  int tests_failed = 0;

  health_manager dut (
    .clk             (clk),
    .rst             (rst),
    .frame_tick      (frame_tick),
    .player_hit      (player_hit),
    .boss_hit        (boss_hit),
    .heal            (heal),
    .restart         (restart),
    .present_health  (present_health),
    .present_bhealth (present_bhealth),
    .player_invuln   (player_invuln),
    .boss_flash      (boss_flash),
    .win             (win),
    .lose            (lose)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, got running, need done");
    $fatal(1, "timeout");
  end

  // Inputs change on the falling edge; outputs are read on the falling edge
  // that follows the rising edge which consumed them.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic pulse_player_hit();
    player_hit = 1'b1;
    step();
    player_hit = 1'b0;
  endtask

  task automatic pulse_boss_hit();
    boss_hit = 1'b1;
    step();
    boss_hit = 1'b0;
  endtask

  task automatic pulse_heal();
    heal = 1'b1;
    step();
    heal = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (present_health !== 4'd3) begin
      $display("FAIL reset_health: got %0d need 3", present_health); tests_failed++;
    end
    tests_run++;
    if (present_bhealth !== 4'd8) begin
      $display("FAIL reset_bhealth: got %0d need 8", present_bhealth); tests_failed++;
    end
    tests_run++;
    if ({player_invuln, boss_flash, win, lose} !== 4'b0000) begin
      $display("FAIL reset_flags: got %b need 0000", {player_invuln, boss_flash, win, lose});
      tests_failed++;
    end
  endtask

  task automatic test_lose();
    do_reset();
    pulse_player_hit();
    tests_run++;
    if (present_health !== 4'd2 || player_invuln !== 1'b1) begin
      $display("FAIL lose_hit1: got hp=%0d inv=%b need hp=2 inv=1", present_health, player_invuln);
      tests_failed++;
    end
    tick_n(61);
    tests_run++;
    if (player_invuln !== 1'b0) begin
      $display("FAIL lose_invuln_end: got %b need 0", player_invuln); tests_failed++;
    end
    pulse_player_hit();
    tests_run++;
    if (present_health !== 4'd1) begin
      $display("FAIL lose_hit2: got %0d need 1", present_health); tests_failed++;
    end
    tick_n(61);
    pulse_player_hit();
    tests_run++;
    if (present_health !== 4'd0 || lose !== 1'b0) begin
      $display("FAIL lose_hit3: got hp=%0d lose=%b need hp=0 lose=0", present_health, lose);
      tests_failed++;
    end
    step();
    tests_run++;
    if (lose !== 1'b1 || win !== 1'b0) begin
      $display("FAIL lose_flag: got lose=%b win=%b need lose=1 win=0", lose, win);
      tests_failed++;
    end
  endtask

  task automatic test_invuln();
    do_reset();
    // Hit coincides with a frame tick: that tick must not count.
    player_hit = 1'b1;
    frame_tick = 1'b1;
    step();
    player_hit = 1'b0;
    frame_tick = 1'b0;
    tests_run++;
    if (present_health !== 4'd2 || player_invuln !== 1'b1) begin
      $display("FAIL invuln_hit: got hp=%0d inv=%b need hp=2 inv=1", present_health, player_invuln);
      tests_failed++;
    end
    tick_n(5);
    pulse_player_hit();
    tests_run++;
    if (present_health !== 4'd2) begin
      $display("FAIL invuln_ignored_hit: got %0d need 2", present_health); tests_failed++;
    end
    tick_n(54);
    tests_run++;
    if (player_invuln !== 1'b1) begin
      $display("FAIL invuln_after_59: got %b need 1", player_invuln); tests_failed++;
    end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    tests_run++;
    if (player_invuln !== 1'b0) begin
      $display("FAIL invuln_after_60: got %b need 0", player_invuln); tests_failed++;
    end
  endtask

  task automatic test_boss();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pulse_boss_hit();
      tests_run++;
      if (present_bhealth !== 4'(7 - i) || boss_flash !== 1'b1) begin
        $display("FAIL boss_hit_%0d: got bhp=%0d flash=%b need bhp=%0d flash=1",
                 i, present_bhealth, boss_flash, 7 - i);
        tests_failed++;
      end
      if (i == 0) begin
        tick_n(3);
        pulse_boss_hit();
        tests_run++;
        if (present_bhealth !== 4'd7) begin
          $display("FAIL boss_cooldown_ignore: got %0d need 7", present_bhealth); tests_failed++;
        end
        tick_n(7);
        tests_run++;
        if (boss_flash !== 1'b0) begin
          $display("FAIL boss_flash_end: got %b need 0", boss_flash); tests_failed++;
        end
        tick_n(1);
      end else if (i < 7) begin
        tick_n(11);
      end
    end
    tests_run++;
    if (win !== 1'b0) begin
      $display("FAIL boss_win_early: got %b need 0", win); tests_failed++;
    end
    step();
    tests_run++;
    if (win !== 1'b1 || lose !== 1'b0) begin
      $display("FAIL boss_win: got win=%b lose=%b need win=1 lose=0", win, lose); tests_failed++;
    end
  endtask

  task automatic test_heal();
    do_reset();
    pulse_heal();
    tests_run++;
    if (present_health !== 4'd3) begin
      $display("FAIL heal_at_max: got %0d need 3", present_health); tests_failed++;
    end
    pulse_player_hit();
    tick_n(60);
    tests_run++;
    if (present_health !== 4'd2 || player_invuln !== 1'b0) begin
      $display("FAIL heal_setup: got hp=%0d inv=%b need hp=2 inv=0", present_health, player_invuln);
      tests_failed++;
    end
    heal = 1'b1;
    player_hit = 1'b1;
    step();
    heal = 1'b0;
    player_hit = 1'b0;
    tests_run++;
    if (present_health !== 4'd1 || player_invuln !== 1'b1) begin
      $display("FAIL heal_vs_hit: got hp=%0d inv=%b need hp=1 inv=1", present_health, player_invuln);
      tests_failed++;
    end
    pulse_heal();
    tests_run++;
    if (present_health !== 4'd2) begin
      $display("FAIL heal_in_invuln: got %0d need 2", present_health); tests_failed++;
    end
    pulse_heal();
    pulse_heal();
    tests_run++;
    if (present_health !== 4'd3) begin
      $display("FAIL heal_saturate: got %0d need 3", present_health); tests_failed++;
    end
  endtask

  task automatic test_double_fatal();
    do_reset();
    pulse_player_hit();
    tick_n(61);
    pulse_player_hit();
    tick_n(61);
    for (int i = 0; i < 7; i++) begin
      pulse_boss_hit();
      tick_n(11);
    end
    tests_run++;
    if (present_health !== 4'd1 || present_bhealth !== 4'd1) begin
      $display("FAIL fatal_setup: got hp=%0d bhp=%0d need hp=1 bhp=1", present_health, present_bhealth);
      tests_failed++;
    end
    player_hit = 1'b1;
    boss_hit = 1'b1;
    step();
    player_hit = 1'b0;
    boss_hit = 1'b0;
    step();
    tests_run++;
    if (lose !== 1'b1 || win !== 1'b0) begin
      $display("FAIL fatal_outcome: got lose=%b win=%b need lose=1 win=0", lose, win);
      tests_failed++;
    end
    player_hit = 1'b1;
    boss_hit = 1'b1;
    heal = 1'b1;
    step();
    player_hit = 1'b0;
    boss_hit = 1'b0;
    heal = 1'b0;
    tick_n(70);
    tests_run++;
    if (present_health !== 4'd0 || present_bhealth !== 4'd0) begin
      $display("FAIL frozen_hp: got hp=%0d bhp=%0d need hp=0 bhp=0", present_health, present_bhealth);
      tests_failed++;
    end
    tests_run++;
    if ({player_invuln, boss_flash, win, lose} !== 4'b1101) begin
      $display("FAIL frozen_flags: got %b need 1101", {player_invuln, boss_flash, win, lose});
      tests_failed++;
    end
  endtask

  task automatic test_restart();
    restart = 1'b1;
    player_hit = 1'b1;
    step();
    restart = 1'b0;
    player_hit = 1'b0;
    tests_run++;
    if (present_health !== 4'd3 || present_bhealth !== 4'd8) begin
      $display("FAIL restart_hp: got hp=%0d bhp=%0d need hp=3 bhp=8", present_health, present_bhealth);
      tests_failed++;
    end
    tests_run++;
    if ({player_invuln, boss_flash, win, lose} !== 4'b0000) begin
      $display("FAIL restart_flags: got %b need 0000", {player_invuln, boss_flash, win, lose});
      tests_failed++;
    end
    pulse_player_hit();
    pulse_boss_hit();
    tests_run++;
    if (present_health !== 4'd2 || player_invuln !== 1'b1 || boss_flash !== 1'b1) begin
      $display("FAIL restart_play: got hp=%0d inv=%b flash=%b need hp=2 inv=1 flash=1",
               present_health, player_invuln, boss_flash);
      tests_failed++;
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (present_health !== 4'd3 || present_bhealth !== 4'd8 ||
        {player_invuln, boss_flash, win, lose} !== 4'b0000) begin
      $display("FAIL async_reset: got hp=%0d bhp=%0d flags=%b need hp=3 bhp=8 flags=0000",
               present_health, present_bhealth, {player_invuln, boss_flash, win, lose});
      tests_failed++;
    end
    step();
    rst = 1'b0;
    tick_n(2);
    tests_run++;
    if (present_health !== 4'd3 || player_invuln !== 1'b0 || boss_flash !== 1'b0) begin
      $display("FAIL post_reset: got hp=%0d inv=%b flash=%b need hp=3 inv=0 flash=0",
               present_health, player_invuln, boss_flash);
      tests_failed++;
    end
  endtask

  initial begin
    test_reset();
    test_lose();
    test_invuln();
    test_boss();
    test_heal();
    test_double_fatal();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/health_manager.md
# health_manager

Game-state block that owns player and boss hit points and produces the `present_health` (0–3) and `present_bhealth` (0–8) values consumed by the HUD bar-drawing logic. It accepts single-cycle hit, heal and restart events from the collision and game-control logic. It enforces player invulnerability frames and a boss damage cooldown, timed in VGA frames. It declares the win/lose outcome and freezes state until restart.

## Interface
- `PLAYER_MAX`, default 3: player HP at reset/restart; must be ≤ 15.
- `BOSS_MAX`, default 8: boss HP at reset/restart; must be ≤ 15.
- `INVULN_FRAMES`, default 60: frame ticks of player invulnerability after a hit; must be ≥ 1.
- `BOSS_CD_FRAMES`, default 10: frame ticks during which further boss hits are ignored; must be ≥ 1.
- `clk` in 1: system/pixel clock, single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse per video frame (end of active area).
- `player_hit` in 1: one-cycle pulse, player struck.
- `boss_hit` in 1: one-cycle pulse, boss struck.
- `heal` in 1: one-cycle pulse, player +1 HP.
- `restart` in 1: one-cycle pulse, reload game.
- `present_health` out 4: current player HP.
- `present_bhealth` out 4: current boss HP.
- `player_invuln` out 1: high while the player is invulnerable (sprite blink).
- `boss_flash` out 1: high while the boss cooldown is active.
- `win` out 1: boss defeated, sticky.
- `lose` out 1: player defeated, sticky.

## Operation
- Game FSM with states PLAY, WIN and LOSE. Reset enters PLAY.
  - PLAY→LOSE when the registered player HP becomes 0.
  - PLAY→WIN when the registered boss HP becomes 0.
  - If both reach 0 in the same cycle, LOSE wins.
  - WIN/LOSE→PLAY only on `restart`.
- Player FSM with states ALIVE and INVULN.
  - In ALIVE, `player_hit` decrements HP by 1 (saturating at 0), loads the invulnerability counter with INVULN_FRAMES and enters INVULN.
  - In INVULN, `player_hit` is ignored.
  - Each `frame_tick` decrements the counter. When a tick arrives with counter==1, the FSM returns to ALIVE.
- `heal`: +1 HP, saturating at PLAYER_MAX. Heal is accepted in both ALIVE and INVULN.
  - If `heal` and an accepted `player_hit` occur in the same cycle, the hit applies and the heal is dropped.
- `boss_hit`: accepted when the cooldown counter is 0. An accepted hit decrements boss HP by 1 (saturating at 0) and loads the cooldown with BOSS_CD_FRAMES. Each `frame_tick` decrements a nonzero cooldown.
- In WIN or LOSE, all hit, heal and tick events are ignored; HP, counters and flags are frozen.
- `restart`, accepted in any game state, has priority over every other event in that cycle. It performs the following:
  - HP ← PLAYER_MAX and BOSS_MAX;
  - both counters ← 0;
  - player FSM → ALIVE, game FSM → PLAY;
  - `win` and `lose` ← 0.
- Width rule: counters are sized with `$clog2(max+1)`. HP arithmetic is 4-bit unsigned with explicit saturation, so there is no wrap-around.

## Timing
- Reset values:
  - `present_health` = PLAYER_MAX, `present_bhealth` = BOSS_MAX;
  - `player_invuln`, `boss_flash`, `win`, `lose` = 0.
- All outputs are registered. An event at cycle N is visible on the outputs at N+1.
- `win`/`lose` assert one cycle after the HP register reads 0, i.e. N+2 after the fatal hit.
- `player_invuln` rises at N+1 after an accepted hit. It stays high for exactly INVULN_FRAMES `frame_tick` pulses and falls the cycle after the final tick.
- `frame_tick` coinciding with the hit cycle does not count toward the invulnerability window; the counter load takes precedence.
- `boss_flash` equals (cooldown != 0), registered.
- Reset asserted mid-operation returns all outputs to their reset values asynchronously. There are no pending events after reset.

## Structure
- Shared game package holds:
  - the game-state enum (PLAY, WIN, LOSE) and the player-state enum (ALIVE, INVULN);
  - HP width constant `HP_W = 4`, used alongside the HUD bar block.
- Natural sub-module: `frame_countdown`. It is a loadable down-counter decremented on `frame_tick`, with a `busy` output. It is instantiated twice, once for invulnerability and once for the boss cooldown.

## Test plan
- Reset, then 3 `player_hit` pulses each 61 frame ticks apart: health 3→2→1→0, and `lose`=1 two cycles after the last hit.
- `player_hit`, then another `player_hit` 5 ticks later: health 3→2 only. `player_invuln` is high for exactly 60 ticks.
- 8 `boss_hit` pulses spaced 11 ticks apart: bhealth 8→0 and `win`=1. A `boss_hit` 3 ticks after an accepted one leaves bhealth unchanged.
- Same-cycle `heal` and `player_hit` at health 2 (ALIVE): result 1. `heal` at health 3: remains 3.
- Final player hit and final boss hit in the same cycle: `lose`=1, `win`=0. Subsequent hits and ticks change nothing.
- In LOSE, pulse `restart` together with `player_hit`: health=3, bhealth=8, all flags 0. Then assert `rst` during INVULN: outputs return to reset values immediately.
